// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: FSM states, word/address types,
// the bubble word and the default halt-request word.
package fetch_stage_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } fetch_state_t;

    localparam word_t NOP_WORD          = 32'h0000_0000;
    localparam word_t DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
    localparam addr_t PC_ALIGN_MASK     = 32'hFFFF_FFFC;

    // Instructions are word aligned: the two low address bits are always zero.
    function automatic addr_t align_pc(input addr_t addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush clears to a bubble and beats hold;
// hold keeps the current contents; otherwise the new values are loaded.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    input  logic        valid_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_plus4_out,
    output logic        valid_out
);

    logic [31:0] instr_d, instr_q;
    logic [31:0] pc_plus4_d, pc_plus4_q;
    logic        valid_d, valid_q;

    // Next register contents: flush > hold > load.
    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush) begin
            instr_d    = NOP_WORD;
            pc_plus4_d = 32'h0000_0000;
            valid_d    = 1'b0;
        end else if (load) begin
            instr_d    = instr_in;
            pc_plus4_d = pc_plus4_in;
            valid_d    = valid_in;
        end else begin
            instr_d    = instr_q;
            pc_plus4_d = pc_plus4_q;
            valid_d    = valid_q;
        end
    end

    // Register with synchronous reset to an empty slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= NOP_WORD;
            pc_plus4_q <= 32'h0000_0000;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_out    = instr_q;
    assign pc_plus4_out = pc_plus4_q;
    assign valid_out    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory address,
// IF/ID register feed, branch redirect, and a halt/drain state machine
// that stops fetching after the halt word and raises a sticky Halt once
// the downstream stages have had time to empty.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD    = DEFAULT_HALT_WORD,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall_F,
    input  logic        Stall_D,
    input  logic        PC_Src_D,
    input  logic [31:0] PC_Branch_D,
    output logic [31:0] Instr_Mem_Addr,
    input  logic [31:0] Instr_Mem_Data,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_Plus4_D,
    output logic        Valid_D,
    output logic        Halt
);

    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

    fetch_state_t state_d, state_q;
    logic [31:0]  pc_d, pc_q;
    logic [7:0]   cnt_d, cnt_q;
    logic         halt_d, halt_q;

    logic [31:0]  pc_plus4_s;
    logic         halt_word_s;
    logic         ifid_flush_s;
    logic         ifid_load_s;
    logic [31:0]  ifid_instr_s;
    logic [31:0]  ifid_pc4_s;
    logic         ifid_valid_s;

    assign pc_plus4_s  = pc_q + 32'd4;
    assign halt_word_s = (Instr_Mem_Data == HALT_WORD);

    // Next PC, FSM state, drain counter and IF/ID control.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        cnt_d        = cnt_q;
        halt_d       = halt_q;
        ifid_flush_s = 1'b0;
        ifid_load_s  = ~Stall_D;
        ifid_instr_s = Instr_Mem_Data;
        ifid_pc4_s   = pc_plus4_s;
        ifid_valid_s = 1'b1;
        case (state_q)
            RUN: begin
                if (PC_Src_D) begin
                    pc_d         = align_pc(PC_Branch_D);
                    ifid_flush_s = 1'b1;
                end else begin
                    // The halt word is never handed to decode, even while
                    // PC is stalled on it.
                    if (halt_word_s) begin
                        ifid_instr_s = NOP_WORD;
                        ifid_pc4_s   = 32'h0000_0000;
                        ifid_valid_s = 1'b0;
                    end else begin
                        ifid_valid_s = 1'b1;
                    end
                    if (halt_word_s && !Stall_F) begin
                        state_d = DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end else if (!Stall_F) begin
                        pc_d = pc_plus4_s;
                    end else begin
                        pc_d = pc_q;
                    end
                end
            end
            DRAIN: begin
                if (PC_Src_D) begin
                    // Halt word was on the wrong path of an older branch.
                    pc_d         = align_pc(PC_Branch_D);
                    ifid_flush_s = 1'b1;
                    cnt_d        = 8'd0;
                    state_d      = RUN;
                end else begin
                    ifid_instr_s = NOP_WORD;
                    ifid_pc4_s   = 32'h0000_0000;
                    ifid_valid_s = 1'b0;
                    if (cnt_q == 8'd0) begin
                        state_d = HALTED;
                        halt_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            HALTED: begin
                ifid_flush_s = 1'b1;
                ifid_load_s  = 1'b0;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // PC, FSM state, drain counter and sticky halt flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= align_pc(RESET_PC);
            cnt_q   <= 8'd0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            halt_q  <= halt_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk          (clk),
        .rst          (rst),
        .flush        (ifid_flush_s),
        .load         (ifid_load_s),
        .instr_in     (ifid_instr_s),
        .pc_plus4_in  (ifid_pc4_s),
        .valid_in     (ifid_valid_s),
        .instr_out    (Instr_D),
        .pc_plus4_out (PC_Plus4_D),
        .valid_out    (Valid_D)
    );

    assign Instr_Mem_Addr = pc_q;
    assign Halt           = halt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a cycle-level reference model of the
// fetch rules, directed scenarios with literal expectations, then random
// stall/branch/halt/reset traffic compared every cycle.
module tb_fetch_stage;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] TAG  = 32'h1234_5679;
    localparam int          DC   = 4;
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;

    logic        clk = 1'b0;
    logic        rst, Stall_F, Stall_D, PC_Src_D;
    logic [31:0] PC_Branch_D;
    logic [31:0] Instr_Mem_Addr, Instr_Mem_Data, Instr_D, PC_Plus4_D;
    logic        Valid_D, Halt;

    logic        halt_en   = 1'b0;
    logic [31:0] halt_addr = 32'h0;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model state (values after the most recent edge).
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halt;
    int          m_mode, m_left;

    fetch_stage #(
        .RESET_PC     (32'h0000_0000),
        .HALT_WORD    (HALT),
        .DRAIN_CYCLES (DC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .Stall_F        (Stall_F),
        .Stall_D        (Stall_D),
        .PC_Src_D       (PC_Src_D),
        .PC_Branch_D    (PC_Branch_D),
        .Instr_Mem_Addr (Instr_Mem_Addr),
        .Instr_Mem_Data (Instr_Mem_Data),
        .Instr_D        (Instr_D),
        .PC_Plus4_D     (PC_Plus4_D),
        .Valid_D        (Valid_D),
        .Halt           (Halt)
    );

    always #5 clk = ~clk;

    // Instruction memory: address-tagged words, one optional halt word.
    assign Instr_Mem_Data = (halt_en && Instr_Mem_Addr == halt_addr) ? HALT
                                                                     : (Instr_Mem_Addr ^ TAG);

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (halt_en && a == halt_addr) ? HALT : (a ^ TAG);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_step();
        logic [31:0] w;
        logic [31:0] npc, ni, np4;
        logic        nv, nh;
        int          nm, nl;
        npc = m_pc; ni = m_instr; np4 = m_pc4; nv = m_valid; nh = m_halt;
        nm = m_mode; nl = m_left;
        w = mem(m_pc);
        if (rst) begin
            npc = 32'h0; ni = 32'h0; np4 = 32'h0; nv = 1'b0; nh = 1'b0;
            nm = M_RUN; nl = 0;
        end else if (m_mode == M_HALTED) begin
            ni = 32'h0; np4 = 32'h0; nv = 1'b0;
        end else if (PC_Src_D) begin
            npc = {PC_Branch_D[31:2], 2'b00};
            ni = 32'h0; np4 = 32'h0; nv = 1'b0;
            nm = M_RUN; nl = 0;
        end else if (m_mode == M_DRAIN) begin
            if (!Stall_D) begin ni = 32'h0; np4 = 32'h0; nv = 1'b0; end
            if (m_left == 0) begin nm = M_HALTED; nh = 1'b1; end
            else nl = m_left - 1;
        end else begin
            if (!Stall_D) begin
                if (w == HALT) begin ni = 32'h0; np4 = 32'h0; nv = 1'b0; end
                else begin ni = w; np4 = m_pc + 32'd4; nv = 1'b1; end
            end
            if (w == HALT && !Stall_F) begin nm = M_DRAIN; nl = DC - 1; end
            else if (!Stall_F) npc = m_pc + 32'd4;
        end
        m_pc = npc; m_instr = ni; m_pc4 = np4; m_valid = nv; m_halt = nh;
        m_mode = nm; m_left = nl;
    endtask

    // Drive one cycle of inputs, update the model, and return just after
    // the following falling edge.
    task automatic cycle(input logic r, input logic sf, input logic sd,
                         input logic ps, input logic [31:0] tgt);
        rst = r; Stall_F = sf; Stall_D = sd; PC_Src_D = ps; PC_Branch_D = tgt;
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("addr",  Instr_Mem_Addr, m_pc);
            check("instr", Instr_D,        m_instr);
            check("pc4",   PC_Plus4_D,     m_pc4);
            check("valid", {31'h0, Valid_D}, {31'h0, m_valid});
            check("halt",  {31'h0, Halt},    {31'h0, m_halt});
        end
    end

    initial begin
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_halt = 1'b0;
        m_mode = M_RUN; m_left = 0;
        rst = 1'b1; Stall_F = 1'b0; Stall_D = 1'b0; PC_Src_D = 1'b0; PC_Branch_D = 32'h0;
        @(negedge clk); #1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_en = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("rst_addr",  Instr_Mem_Addr, 32'h0);
        check("rst_instr", Instr_D, 32'h0);
        check("rst_valid", {31'h0, Valid_D}, 32'h0);
        check("rst_halt",  {31'h0, Halt}, 32'h0);

        // Free-run from reset.
        run(1);
        check("run_addr4",  Instr_Mem_Addr, 32'h4);
        check("run_instr0", Instr_D, 32'h1234_5679);
        check("run_pc4",    PC_Plus4_D, 32'h4);
        check("run_valid",  {31'h0, Valid_D}, 32'h1);
        run(1);
        check("run_addr8",  Instr_Mem_Addr, 32'h8);

        // Stall both at PC=8 for three cycles, then resume.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("stall_addr",  Instr_Mem_Addr, 32'h8);
        check("stall_instr", Instr_D, 32'h1234_567D);
        run(1);
        check("resume_addr", Instr_Mem_Addr, 32'hC);
        run(1);

        // Redirect at PC=16 with Stall_D also high: flush wins.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
        check("br_addr",  Instr_Mem_Addr, 32'h100);
        check("br_instr", Instr_D, 32'h0);
        check("br_valid", {31'h0, Valid_D}, 32'h0);

        // Halt word at address 20.
        halt_en = 1'b1; halt_addr = 32'd20;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        run(6);
        check("drn_addr",  Instr_Mem_Addr, 32'd20);
        check("drn_valid", {31'h0, Valid_D}, 32'h0);
        run(3);
        check("drn_nohalt", {31'h0, Halt}, 32'h0);
        run(1);
        check("halt_rise", {31'h0, Halt}, 32'h1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
        check("halt_hold", {31'h0, Halt}, 32'h1);
        check("halt_addr", Instr_Mem_Addr, 32'd20);
        check("halt_instr", Instr_D, 32'h0);

        // Wrong-path halt: redirect during DRAIN returns to RUN.
        halt_addr = 32'd8;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        run(3);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
        check("wp_addr", Instr_Mem_Addr, 32'h40);
        run(8);
        check("wp_nohalt", {31'h0, Halt}, 32'h0);

        // PC wrap at the top of the address space.
        halt_en = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        run(1);
        check("wrap_addr",  Instr_Mem_Addr, 32'h0);
        check("wrap_instr", Instr_D, 32'hEDCB_A985);
        check("wrap_pc4",   PC_Plus4_D, 32'h0);

        // Reset in the middle of DRAIN.
        halt_en = 1'b1; halt_addr = 32'd4;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        run(4);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("rstdrn_addr", Instr_Mem_Addr, 32'h0);
        check("rstdrn_halt", {31'h0, Halt}, 32'h0);

        // Randomized traffic.
        halt_en = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                halt_en = 1'b1;
                halt_addr = m_pc + 32'(4 * $urandom_range(0, 3));
            end else if ($urandom_range(0, 31) == 0) begin
                halt_en = 1'b0;
            end
            cycle(($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255)));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
